// File: rtl/inc16_arbiter.sv
// inc16_arbiter: round-robin sharing of one external incrementer among
// N_REQ valid/ready requesters. Results are parked in a single response slot
// tagged with the winning requester id.
module inc16_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]       inc_a_o,
    input  logic [WIDTH-1:0]       inc_y_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [WIDTH-1:0]       rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic                   rsp_ovf_o,
    output logic                   busy_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    logic              accept_en;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand;
    logic              transfer;

    // The slot can take a new result when empty, or when full and draining this cycle
    assign accept_en = (state_q == EMPTY) || rsp_ready_i;
    assign transfer  = accept_en && grant_found;

    // Round-robin scan: first valid requester at or after the pointer, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid_i[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // One-hot grant and operand mux; both stay zero whenever the slot is blocked
    always_comb begin
        req_ready_o = '0;
        inc_a_o     = '0;
        if (transfer) begin
            req_ready_o[grant_idx] = 1'b1;
            inc_a_o                = req_data_i[int'(grant_idx)*WIDTH +: WIDTH];
        end
    end

    // Next-state: capture the incrementer result on a transfer, otherwise hold or drain
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_ovf_d  = rsp_ovf_q;
        if (transfer) begin
            state_d    = FULL;
            ptr_d      = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            rsp_data_d = inc_y_i;
            rsp_id_d   = grant_idx;
            rsp_ovf_d  = (inc_y_i == '0);
        end else if ((state_q == FULL) && rsp_ready_i) begin
            state_d = EMPTY;
        end
    end

    // Slot state, round-robin pointer and registered response fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_ovf_o   = rsp_ovf_q;
    assign busy_o      = rsp_valid_o && !rsp_ready_i;

endmodule

// File: tb/tb_inc16_arbiter.sv
// Directed bench for inc16_arbiter with a behavioural inc16 attached.
module tb_inc16_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       reqValid;
    logic [N_REQ*WIDTH-1:0] reqDataBus;
    logic [N_REQ-1:0]       reqReady;
    logic [WIDTH-1:0]       incA;
    logic [WIDTH-1:0]       incY;
    logic                   rspValid;
    logic                   rspReady;
    logic [WIDTH-1:0]       rspData;
    logic [ID_W-1:0]        rspId;
    logic                   rspOvf;
    logic                   busy;

    logic [WIDTH-1:0]       reqData [N_REQ];

    int passCount;
    int totalCount;

    inc16_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (reqValid),
        .req_data_i  (reqDataBus),
        .req_ready_o (reqReady),
        .inc_a_o     (incA),
        .inc_y_i     (incY),
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_data_o  (rspData),
        .rsp_id_o    (rspId),
        .rsp_ovf_o   (rspOvf),
        .busy_o      (busy)
    );

    // Shared incrementer: combinational, wraps modulo 2^16
    assign incY = incA + 16'd1;

    // Pack per-requester operands onto the flat bus
    always_comb begin
        reqDataBus = {reqData[3], reqData[2], reqData[1], reqData[0]};
    end

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the sequence never reaches its end
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, totalCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic ready);
        reqValid = valid;
        rspReady = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic [15:0] d,
                            input logic [1:0] id, input logic ovf);
        checkOutput({tag, ".valid"}, 32'(rspValid), 32'(v));
        checkOutput({tag, ".data"},  32'(rspData),  32'(d));
        checkOutput({tag, ".id"},    32'(rspId),    32'(id));
        checkOutput({tag, ".ovf"},   32'(rspOvf),   32'(ovf));
    endtask

    logic [15:0] rotData [4];

    initial begin
        passCount  = 0;
        totalCount = 0;
        rst        = 1'b1;
        reqValid   = '0;
        rspReady   = 1'b0;
        for (int i = 0; i < N_REQ; i++) reqData[i] = '0;

        // Reset state
        tick();
        tick();
        checkRsp("reset", 1'b0, 16'h0000, 2'd0, 1'b0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Basic increment from requester 0
        reqData[0] = 16'h0000;
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t1.ready", 32'(reqReady), 32'h1);
        checkOutput("t1.inca",  32'(incA),     32'h0000);
        tick();
        checkRsp("t1", 1'b1, 16'h0001, 2'd0, 1'b0);

        // Wrap to zero raises overflow, ordinary carry does not
        reqData[0] = 16'hFFFF;
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t2a.ready", 32'(reqReady), 32'h1);
        tick();
        checkRsp("t2a", 1'b1, 16'h0000, 2'd0, 1'b1);
        reqData[0] = 16'h0FFF;
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkRsp("t2b", 1'b1, 16'h1000, 2'd0, 1'b0);

        // Move pointer back to 0 through a lone requester 3 transfer
        reqData[3] = 16'hFFFE;
        applyStimulus(4'b1000, 1'b1);
        checkOutput("t3pre.ready", 32'(reqReady), 32'h8);
        tick();
        checkRsp("t3pre", 1'b1, 16'hFFFF, 2'd3, 1'b0);

        // All four valid: rotation 0,1,2,3,0,1,2,3
        reqData[0] = 16'h1234;
        reqData[1] = 16'h5555;
        reqData[2] = 16'hAAAA;
        reqData[3] = 16'hFFFE;
        rotData[0] = 16'h1235;
        rotData[1] = 16'h5556;
        rotData[2] = 16'hAAAB;
        rotData[3] = 16'hFFFF;
        applyStimulus(4'b1111, 1'b1);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("t3.ready%0d", c), 32'(reqReady), 32'(4'b0001 << (c % 4)));
            tick();
            checkRsp($sformatf("t3.rsp%0d", c), 1'b1, rotData[c % 4], 2'(c % 4), 1'b0);
        end

        // Back-pressure: slot blocked, held, then drained and refilled without a bubble
        reqData[0] = 16'h0010;
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkRsp("t4a", 1'b1, 16'h0011, 2'd0, 1'b0);
        reqData[1] = 16'h00AB;
        applyStimulus(4'b0010, 1'b0);
        checkOutput("t4.busy",  32'(busy),     32'd1);
        checkOutput("t4.ready", 32'(reqReady), 32'h0);
        checkOutput("t4.inca",  32'(incA),     32'h0000);
        tick();
        checkRsp("t4hold1", 1'b1, 16'h0011, 2'd0, 1'b0);
        tick();
        checkRsp("t4hold2", 1'b1, 16'h0011, 2'd0, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("t4.busyOff", 32'(busy),     32'd0);
        checkOutput("t4.ready1",  32'(reqReady), 32'h2);
        checkOutput("t4.inca1",   32'(incA),     32'h00AB);
        tick();
        checkRsp("t4refill", 1'b1, 16'h00AC, 2'd1, 1'b0);

        // Pointer at 2 with only requesters 0 and 3 valid: 3 wins first
        reqData[0] = 16'h0100;
        reqData[3] = 16'h0300;
        applyStimulus(4'b1001, 1'b1);
        checkOutput("t5.ready3", 32'(reqReady), 32'h8);
        tick();
        checkRsp("t5a", 1'b1, 16'h0301, 2'd3, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t5.ready0", 32'(reqReady), 32'h1);
        tick();
        checkRsp("t5b", 1'b1, 16'h0101, 2'd0, 1'b0);

        // Drain with no new request empties the slot
        applyStimulus(4'b0000, 1'b1);
        checkOutput("drain.ready", 32'(reqReady), 32'h0);
        tick();
        checkOutput("drain.valid", 32'(rspValid), 32'd0);

        // Asynchronous reset while full with everyone requesting
        reqData[2] = 16'h2000;
        applyStimulus(4'b1111, 1'b1);
        checkOutput("t6.ready1", 32'(reqReady), 32'h2);
        tick();
        checkRsp("t6pre", 1'b1, 16'h00AC, 2'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkRsp("t6rst", 1'b0, 16'h0000, 2'd0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t6.ready0", 32'(reqReady), 32'h1);
        checkOutput("t6.inca",   32'(incA),     32'h0100);
        tick();
        checkRsp("t6post", 1'b1, 16'h0101, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
